// File: rtl/tap_host_pkg.sv
// Shared definitions for the TAP host driver: default widths, reset length
// and the controller state encoding.
package tap_host_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_RESULT_WIDTH = 16;
  localparam int TAP_RST_CYCLES   = 5;

  typedef enum logic [3:0] {
    ST_TAP_RST,
    ST_IDLE,
    ST_SHIFT_IN,
    ST_UPDATE,
    ST_WAIT,
    ST_CAPTURE,
    ST_SHIFT_OUT,
    ST_CHECK,
    ST_DONE
  } tap_state_e;

endpackage

// File: rtl/tap_host_driver_bit_shifter.sv
// LSB-first shift register: parallel load then serial out from bit 0, while
// serial input enters at the MSB so the first sampled bit ends up in bit 0.
module tap_bit_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             load_i,
  input  logic [WIDTH-1:0] par_i,
  input  logic             shift_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] par_o
);

  logic [WIDTH-1:0] sh_q;

  always_ff @(posedge clk) begin
    if (load_i) begin
      sh_q <= par_i;
    end else if (shift_i) begin
      sh_q <= {ser_i, sh_q[WIDTH-1:1]};
    end
  end

  assign par_o = sh_q;

endmodule

// File: rtl/tap_host_driver.sv
// Host-side JTAG DR driver: shifts puzzle bytes into a target, then polls a
// result register until it reads non-zero or the poll budget runs out.
module tap_host_driver
  import tap_host_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int RESULT_WIDTH  = DEF_RESULT_WIDTH,
  parameter int POLL_INTERVAL = 64,
  parameter int MAX_POLLS     = 255
) (
  input  logic                    clk,
  input  logic                    test_logic_reset,
  output logic                    in_ready,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_last,
  output logic                    tap_reset,
  output logic                    ir_is_user,
  output logic                    capture_dr,
  output logic                    shift_dr,
  output logic                    update_dr,
  output logic                    tdi,
  input  logic                    tdo,
  output logic                    result_valid,
  output logic [RESULT_WIDTH-1:0] result_data,
  output logic                    result_timeout,
  output logic                    busy
);

  localparam int SW    = (DATA_WIDTH > RESULT_WIDTH) ? DATA_WIDTH : RESULT_WIDTH;
  localparam int CMAX0 = (SW > POLL_INTERVAL) ? SW : POLL_INTERVAL;
  localparam int CMAX  = (CMAX0 > TAP_RST_CYCLES) ? CMAX0 : TAP_RST_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int PW    = $clog2(MAX_POLLS + 1);

  tap_state_e              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [PW-1:0]           poll_q, poll_d;
  logic                    last_q, last_d;
  logic [RESULT_WIDTH-1:0] rdata_q, rdata_d;
  logic                    rvalid_q, rvalid_d;
  logic                    rtimeout_q, rtimeout_d;
  logic                    tdi_q, tdi_d;
  logic                    tap_reset_q, ir_user_q, in_ready_q, busy_q;
  logic                    cap_q, shift_q, upd_q;
  logic                    sh_load, sh_shift;
  logic [SW-1:0]           sh_load_val, sh_q;
  logic [RESULT_WIDTH-1:0] rx_word;

  // One register serves both directions; bit 0 of the byte goes straight to
  // tdi at the handshake, so only the upper bits are preloaded.
  tap_bit_shifter #(.WIDTH(SW)) u_shifter (
    .clk     (clk),
    .load_i  (sh_load),
    .par_i   (sh_load_val),
    .shift_i (sh_shift),
    .ser_i   (tdo),
    .par_o   (sh_q)
  );

  assign rx_word = sh_q[SW-1 -: RESULT_WIDTH];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    poll_d      = poll_q;
    last_d      = last_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    rtimeout_d  = 1'b0;
    tdi_d       = 1'b0;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
    sh_load_val = '0;
    sh_load_val[DATA_WIDTH-2:0] = in_data[DATA_WIDTH-1:1];
    unique case (state_q)
      ST_TAP_RST: begin
        if (cnt_q == CW'(TAP_RST_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          sh_load = 1'b1;
          last_d  = in_last;
          tdi_d   = in_data[0];
          state_d = ST_SHIFT_IN;
          cnt_d   = '0;
        end
      end
      ST_SHIFT_IN: begin
        sh_shift = 1'b1;
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          state_d = ST_UPDATE;
          cnt_d   = '0;
        end else begin
          tdi_d = sh_q[0];
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_UPDATE: begin
        cnt_d = '0;
        if (last_q) begin
          state_d = ST_WAIT;
          poll_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CW'(POLL_INTERVAL - 1)) begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_SHIFT_OUT;
        cnt_d   = '0;
      end
      ST_SHIFT_OUT: begin
        sh_shift = 1'b1;
        if (cnt_q == CW'(RESULT_WIDTH - 1)) begin
          state_d = ST_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CHECK: begin
        if (rx_word != '0) begin
          rdata_d  = rx_word;
          rvalid_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          poll_d = poll_q + 1'b1;
          if (poll_d == PW'(MAX_POLLS)) begin
            rtimeout_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_TAP_RST;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_TAP_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Every TAP-facing output is decoded from the next state and registered,
  // so it lines up with the state it belongs to and never glitches.
  always_ff @(posedge clk) begin
    if (test_logic_reset) begin
      state_q     <= ST_TAP_RST;
      cnt_q       <= '0;
      poll_q      <= '0;
      last_q      <= 1'b0;
      tap_reset_q <= 1'b1;
      ir_user_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      cap_q       <= 1'b0;
      shift_q     <= 1'b0;
      upd_q       <= 1'b0;
      tdi_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      rtimeout_q  <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      poll_q      <= poll_d;
      last_q      <= last_d;
      tap_reset_q <= (state_d == ST_TAP_RST);
      ir_user_q   <= (state_d != ST_TAP_RST);
      in_ready_q  <= (state_d == ST_IDLE);
      cap_q       <= (state_d == ST_CAPTURE);
      shift_q     <= (state_d == ST_SHIFT_IN) || (state_d == ST_SHIFT_OUT);
      upd_q       <= (state_d == ST_UPDATE);
      tdi_q       <= tdi_d;
      rvalid_q    <= rvalid_d;
      rtimeout_q  <= rtimeout_d;
      rdata_q     <= rdata_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign in_ready       = in_ready_q;
  assign tap_reset      = tap_reset_q;
  assign ir_is_user     = ir_user_q;
  assign capture_dr     = cap_q;
  assign shift_dr       = shift_q;
  assign update_dr      = upd_q;
  assign tdi            = tdi_q;
  assign result_valid   = rvalid_q;
  assign result_timeout = rtimeout_q;
  assign result_data    = rdata_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_tap_host_driver.sv
// Directed and randomized bench for tap_host_driver with a behavioural
// loopback target and a transaction-level model of the polling outcome.
module tb_tap_host_driver;
  import tap_host_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int RW = DEF_RESULT_WIDTH;
  localparam int PI = 64;
  localparam int MP = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_ready, in_valid, in_last;
  logic [DW-1:0] in_data;
  logic          tap_reset, ir_is_user, capture_dr, shift_dr, update_dr, tdi, tdo;
  logic          result_valid, result_timeout, busy;
  logic [RW-1:0] result_data;

  always #5 clk = ~clk;

  tap_host_driver #(
    .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .POLL_INTERVAL(PI), .MAX_POLLS(MP)
  ) dut (
    .clk(clk), .test_logic_reset(rst),
    .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .tap_reset(tap_reset), .ir_is_user(ir_is_user), .capture_dr(capture_dr),
    .shift_dr(shift_dr), .update_dr(update_dr), .tdi(tdi), .tdo(tdo),
    .result_valid(result_valid), .result_data(result_data),
    .result_timeout(result_timeout), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Loopback target: loads the next queued response on capture, shifts it out LSB first.
  logic [RW-1:0] resp_q[$];
  logic [RW-1:0] tword = '0;
  always @(posedge clk) begin
    if (capture_dr) begin
      if (resp_q.size() > 0) tword <= resp_q.pop_front();
      else tword <= '0;
    end else if (shift_dr) begin
      tword <= tword >> 1;
    end
  end
  assign tdo = tword[0];

  // Monitor: rebuilds inbound bytes from tdi and counts strobes and pulses.
  int n_upd = 0, n_cap = 0, n_rv = 0, n_rt = 0, n_viol = 0, nbits = 0;
  bit out_phase = 0;
  logic [DW-1:0] cur = '0;
  logic [DW-1:0] rx_bytes[$];
  logic [DW-1:0] exp_bytes[$];
  always @(negedge clk) begin
    if ((int'(capture_dr) + int'(shift_dr) + int'(update_dr)) > 1) n_viol++;
    if (result_valid && result_timeout) n_viol++;
    if (result_valid) n_rv++;
    if (result_timeout) n_rt++;
    if (capture_dr) begin
      n_cap++;
      out_phase = 1;
    end
    if (tap_reset) begin
      nbits = 0;
      out_phase = 0;
    end else if (shift_dr && !out_phase) begin
      if (nbits < DW) cur[nbits] = tdi;
      nbits++;
    end
    if (update_dr) begin
      n_upd++;
      if (nbits != DW) n_viol++;
      rx_bytes.push_back(cur);
      nbits = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [DW-1:0] d, input bit last);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (in_ready !== 1'b1 && t < 500) begin
      tick();
      t++;
    end
    if (t >= 500) check("handshake_bound", 64'(t), 64'(0));
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_bytes.push_back(d);
  endtask

  // Waits for tap_reset to rise, then measures how long it stays high.
  task automatic tap_reset_run(output int n);
    int t;
    t = 0;
    while (tap_reset !== 1'b1 && t < 5000) begin
      tick();
      t++;
    end
    n = 0;
    while (tap_reset === 1'b1 && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_result(output int t);
    t = 0;
    while (result_valid !== 1'b1 && result_timeout !== 1'b1 && t < 5000) begin
      tick();
      t++;
    end
  endtask

  // Outcome of a poll sequence: first non-zero word within MP reads wins.
  task automatic model(input logic [RW-1:0] r[$], output bit ok, output logic [RW-1:0] val,
                       output int caps);
    logic [RW-1:0] w;
    ok = 0; val = '0; caps = MP;
    for (int i = 0; i < MP; i++) begin
      w = (i < r.size()) ? r[i] : '0;
      if (w != '0) begin
        ok = 1; val = w; caps = i + 1;
        return;
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t, base_cap, base_rv, base_rt, base_upd, base_rx, caps, nb, errs;
    bit ok;
    logic [RW-1:0] val, held;
    logic [RW-1:0] r[$];
    logic [DW-1:0] a5;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_tap_reset", tap_reset, 1);
    check("rst_ir_user", ir_is_user, 0);
    check("rst_strobes", {capture_dr, shift_dr, update_dr, tdi}, 0);
    check("rst_results", {result_valid, result_timeout}, 0);
    check("rst_result_data", result_data, 0);
    check("rst_busy", busy, 1);
    rst = 1'b0;
    tap_reset_run(n);
    check("rst_tap_reset_len", n, 5);
    check("idle_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_ir_user", ir_is_user, 1);

    // Byte 0xA5 without in_last: bit pattern, update, ready after 10 cycles.
    a5 = 8'hA5;
    send_byte(a5, 0);
    for (int k = 0; k < DW; k++) begin
      check($sformatf("a5_shift_%0d", k), shift_dr, 1);
      check($sformatf("a5_tdi_%0d", k), tdi, (a5 >> k) & 1);
      check($sformatf("a5_rdy_%0d", k), {in_ready, update_dr}, 0);
      tick();
    end
    check("a5_update", {update_dr, shift_dr, tdi, in_ready}, 4'b1000);
    tick();
    check("a5_ready_10", in_ready, 1);

    // Three bytes, last on third; target answers 0, 0, 0x1234.
    resp_q.delete();
    r = '{16'h0000, 16'h0000, 16'h1234};
    foreach (r[i]) resp_q.push_back(r[i]);
    model(r, ok, val, caps);
    base_cap = n_cap; base_rv = n_rv; base_rt = n_rt;
    for (int i = 0; i < 3; i++) send_byte(DW'($urandom), i == 2);
    t = 0;
    while (update_dr !== 1'b1 && t < 50) begin tick(); t++; end
    check("poll_update_seen", update_dr, 1);
    tick();
    n = 0;
    while (capture_dr !== 1'b1 && n < 500) begin n++; tick(); end
    check("poll_wait_len", n, PI);
    tick();
    n = 0;
    while (shift_dr === 1'b1 && n < 100) begin n++; tick(); end
    check("poll_shift_out_len", n, RW);
    wait_result(t);
    check("poll_valid", {result_valid, result_timeout}, {ok, !ok});
    check("poll_data", result_data, val);
    tick();
    check("poll_valid_pulse", result_valid, 0);
    tap_reset_run(n);
    check("poll_tap_reset_len", n, 5);
    check("poll_back_idle", in_ready, 1);
    check("poll_captures", n_cap - base_cap, caps);
    check("poll_valid_count", n_rv - base_rv, 1);
    check("poll_timeout_count", n_rt - base_rt, 0);
    held = result_data;
    check("poll_data_held", held, 16'h1234);

    // Single byte with in_last, target always zero: timeout after MP reads.
    resp_q.delete();
    r.delete();
    model(r, ok, val, caps);
    base_cap = n_cap; base_rv = n_rv; base_rt = n_rt;
    send_byte(DW'($urandom), 1);
    wait_result(t);
    check("to_pulse", {result_valid, result_timeout}, {ok, !ok});
    tick();
    check("to_pulse_len", result_timeout, 0);
    tap_reset_run(n);
    check("to_tap_reset_len", n, 5);
    check("to_back_idle", in_ready, 1);
    check("to_captures", n_cap - base_cap, caps);
    check("to_valid_count", n_rv - base_rv, 0);
    check("to_timeout_count", n_rt - base_rt, 1);
    check("to_data_held", result_data, held);

    // Reset during the 4th SHIFT_IN cycle aborts the byte.
    base_upd = n_upd; base_rx = rx_bytes.size();
    in_valid = 1'b1; in_data = DW'($urandom); in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("abort_in_shift", shift_dr, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_shift_low", shift_dr, 0);
    check("abort_tap_reset", tap_reset, 1);
    check("abort_result_data", result_data, 0);
    check("abort_busy", {busy, in_ready}, 2'b10);
    tap_reset_run(n);
    check("abort_tap_reset_len", n, 5);
    check("abort_no_update", n_upd - base_upd, 0);
    check("abort_no_byte", rx_bytes.size() - base_rx, 0);
    check("abort_idle", in_ready, 1);

    // Randomized runs: gapped byte streams and random poll responses.
    for (int run = 0; run < 4; run++) begin
      exp_bytes.delete();
      rx_bytes.delete();
      resp_q.delete();
      r.delete();
      for (int j = 0; j < MP; j++)
        r.push_back(($urandom_range(0, 2) == 0) ? RW'($urandom) : RW'(0));
      foreach (r[i]) resp_q.push_back(r[i]);
      model(r, ok, val, caps);
      base_cap = n_cap; base_rv = n_rv; base_rt = n_rt;
      nb = (run == 0) ? 1000 : int'($urandom_range(1, 3));
      for (int i = 0; i < nb; i++) begin
        repeat ($urandom_range(0, 4)) tick();
        send_byte(DW'($urandom), i == nb - 1);
      end
      wait_result(t);
      check($sformatf("rnd%0d_outcome", run), {result_valid, result_timeout}, {ok, !ok});
      if (ok) check($sformatf("rnd%0d_data", run), result_data, val);
      tap_reset_run(n);
      check($sformatf("rnd%0d_tap_reset_len", run), n, 5);
      check($sformatf("rnd%0d_captures", run), n_cap - base_cap, caps);
      check($sformatf("rnd%0d_pulses", run), {n_rv - base_rv, n_rt - base_rt},
            {32'(ok ? 1 : 0), 32'(ok ? 0 : 1)});
      check($sformatf("rnd%0d_byte_count", run), rx_bytes.size(), exp_bytes.size());
      errs = 0;
      for (int i = 0; i < exp_bytes.size() && i < rx_bytes.size(); i++)
        if (rx_bytes[i] !== exp_bytes[i]) errs++;
      check($sformatf("rnd%0d_byte_errors", run), errs, 0);
    end

    check("strobe_violations", n_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tap_host_driver.md
TAP_HOST_DRIVER -- requirements
Module: tap_host_driver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the bits per inbound byte shifted on TDI.
REQ-002 SHALL have parameter RESULT_WIDTH, default 16, giving the bits read back on TDO per poll.
REQ-003 SHALL have parameter POLL_INTERVAL, default 64, giving the idle cycles before each result read.
REQ-004 SHALL have parameter MAX_POLLS, default 255, giving the zero-valued reads allowed before timeout.
REQ-005 SHALL have ports, in this order:
- clk  in  1  single clock; all logic on the rising edge.
- test_logic_reset  in  1  synchronous, active-high reset.
- in_ready  out  1  byte slot free.
- in_valid  in  1  byte offered.
- in_data  in  DATA_WIDTH  byte to shift.
- in_last  in  1  final byte of puzzle input.
- tap_reset  out  1  drives the target's test_logic_reset.
- ir_is_user  out  1  user IR selected.
- capture_dr  out  1  target capture strobe.
- shift_dr  out  1  target shift enable.
- update_dr  out  1  target update strobe.
- tdi  out  1  serial data to target.
- tdo  in  1  serial data from target.
- result_valid  out  1  one-cycle pulse, result_data good.
- result_data  out  RESULT_WIDTH  last non-zero read value.
- result_timeout  out  1  one-cycle pulse, MAX_POLLS exhausted.
- busy  out  1  high in every state except IDLE.

Function
REQ-006 SHALL implement states TAP_RST, IDLE, SHIFT_IN, UPDATE, WAIT, CAPTURE, SHIFT_OUT, CHECK, DONE.
REQ-007 TAP_RST SHALL hold tap_reset=1 for exactly 5 cycles, with all other TAP outputs 0, then go to IDLE.
REQ-008 IDLE SHALL assert in_ready; on in_valid&&in_ready it SHALL latch in_data and in_last and go to SHIFT_IN on the next cycle.
REQ-009 in_ready SHALL be low in every state except IDLE.
REQ-010 ir_is_user SHALL be 1 in all states except TAP_RST.
REQ-011 SHIFT_IN SHALL last DATA_WIDTH cycles with shift_dr=1 and tdi=bit k of the latched byte in cycle k, LSB first.
REQ-012 UPDATE SHALL last 1 cycle with update_dr=1, shift_dr=0 and tdi=0; next state is IDLE, or WAIT if the latched in_last=1.
REQ-013 Each byte SHALL therefore occupy DATA_WIDTH+2 cycles from handshake to the next in_ready.
REQ-014 WAIT SHALL count POLL_INTERVAL cycles, then go to CAPTURE.
REQ-015 CAPTURE SHALL last 1 cycle with capture_dr=1.
REQ-016 SHIFT_OUT SHALL last RESULT_WIDTH cycles with shift_dr=1 and tdi=0, sampling tdo at each rising edge where shift_dr=1 into bit k of a shift register, LSB first.
REQ-017 CHECK SHALL last 1 cycle and branch as follows:
- read value non-zero: load result_data, pulse result_valid, go to DONE.
- read value zero: increment the poll counter; at MAX_POLLS pulse result_timeout and go to DONE, otherwise go to WAIT.
REQ-018 result_valid and result_timeout SHALL never be high in the same cycle.
REQ-019 result_data SHALL hold its value until the next result_valid or reset.
REQ-020 DONE SHALL last 1 cycle, then go to TAP_RST, leaving the block ready for a new run.
REQ-021 The poll counter SHALL be sized $clog2(MAX_POLLS+1) bits and SHALL clear on each entry from UPDATE into WAIT.
REQ-022 tap_reset, ir_is_user, capture_dr, shift_dr, update_dr and tdi SHALL be driven directly from flops (glitch-free).
REQ-023 capture_dr, shift_dr and update_dr SHALL be mutually exclusive in every cycle.
REQ-024 in_last on a byte SHALL be honoured even when it is the first byte of a run.

Reset
REQ-025 On test_logic_reset=1 the state SHALL become TAP_RST with its 5-cycle counter restarted, including when reset arrives mid-operation.
REQ-026 Reset values SHALL be:
- in_ready=0, capture_dr=0, shift_dr=0, update_dr=0, tdi=0, ir_is_user=0.
- result_valid=0, result_timeout=0, result_data=0, busy=1.
- poll counter 0; any in-progress byte is discarded.

Structure
REQ-027 DATA_WIDTH (8) and RESULT_WIDTH (16) defaults and the state enum SHALL live in shared package tap_host_pkg, also used by the bench.
REQ-028 The optional sub-module tap_bit_shifter SHALL be a parameterised-width LSB-first parallel-to-serial and serial-to-parallel register; no other sub-modules.

Verification
REQ-029 Byte 0xA5 with in_last=0: tdi = 1,0,1,0,0,1,0,1 over 8 shift_dr cycles, then one update_dr pulse, then in_ready=1 exactly 10 cycles after the handshake.
REQ-030 Three bytes with in_last on the third: after the third UPDATE, capture_dr rises 64 cycles later, followed by 16 shift_dr cycles.
REQ-031 Loopback target returning 0x0000 twice then 0x1234 (LSB first): result_valid pulses once with result_data=0x1234, and exactly 3 captures occur.
REQ-032 MAX_POLLS=3 with a target always returning 0: result_timeout pulses once after the 3rd read, result_valid never pulses, and the block reaches IDLE via a 5-cycle tap_reset.
REQ-033 test_logic_reset asserted in cycle 4 of SHIFT_IN: next cycle shift_dr=0, tap_reset=1 for 5 cycles, and the byte is not completed with update_dr.
REQ-034 Random in_valid gaps across 1000 bytes: no byte is lost or duplicated, and the control strobes are never asserted together in any cycle.
